// File: rtl/cafeteira_pkg.sv
// Shared constants for the coffee-maker status transmitter: ASCII event
// codes, heartbeat prefix, event bit positions and TX state encoding.
package cafeteira_pkg;

   localparam logic [7:0] COD_FIM        = 8'h46;  // 'F'
   localparam logic [7:0] COD_SEM_XICARA = 8'h58;  // 'X'
   localparam logic [7:0] COD_TIMEOUT    = 8'h54;  // 'T'
   localparam logic [2:0] HB_PREFIX      = 3'b101;

   // Bit positions inside the 3-bit event vectors
   localparam int unsigned EV_W   = 3;
   localparam int unsigned EV_FIM = 0;
   localparam int unsigned EV_SEM = 1;
   localparam int unsigned EV_TMO = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// Plain 8N1 UART transmitter. A byte offered on partida/dados is taken
// while idle or on the last stop cycle, so frames can run back-to-back.
module uart_tx_8n1
   import cafeteira_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [7:0] dados,
   output logic       saida,
   output logic       ocupado,
   output logic       pronto,
   output logic [1:0] estado
);

   localparam int unsigned CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   tx_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shifter, shift_n;
   logic          saida_n, ocupado_n, pronto_n;
   logic          last_c, carrega_c;

   assign last_c = (cnt == LAST);
   assign estado = state;

   // State, counters, shifter and registered line outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shifter <= '0;
         saida   <= 1'b1;
         ocupado <= 1'b0;
         pronto  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shifter <= shift_n;
         saida   <= saida_n;
         ocupado <= ocupado_n;
         pronto  <= pronto_n;
      end
   end

   // Next-state, counter and shifter update; outputs follow the next state
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_n     = bit_idx;
      shift_n   = shifter;
      carrega_c = 1'b0;
      saida_n   = 1'b1;

      case (state)
         IDLE: carrega_c = partida;
         START: begin
            if (last_c) begin
               cnt_n   = '0;
               state_n = DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (last_c) begin
               cnt_n   = '0;
               shift_n = {1'b0, shifter[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         STOP: begin
            if (last_c) begin
               cnt_n = '0;
               if (partida) begin
                  carrega_c = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      if (carrega_c) begin
         state_n = START;
         cnt_n   = '0;
         bit_n   = '0;
         shift_n = dados;
      end

      case (state_n)
         START:   saida_n = 1'b0;
         DATA:    saida_n = shift_n[0];
         default: saida_n = 1'b1;
      endcase

      ocupado_n = (state_n != IDLE);
      pronto_n  = (state_n == STOP) && (cnt_n == LAST);
   end

endmodule

// File: rtl/cafeteira_status_tx.sv
// Status reporter: detects rising edges of the controller's fim / error
// levels, keeps one pending flag per event and sends each as an ASCII byte
// over an 8N1 line to the ESP (priority X > T > F > heartbeat).
// Optional macro STATUS_HEARTBEAT_EN adds a periodic {3'b101, db_estado} byte.
module cafeteira_status_tx
   import cafeteira_pkg::*;
#(
   parameter int unsigned BAUD_DIV      = 434,
   parameter int unsigned HEARTBEAT_DIV = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fim,
   input  logic       erro_sem_xicara,
   input  logic       erro_timeout_ebulidor,
   input  logic [4:0] db_estado,
   output logic       tx_esp,
   output logic       ocupado,
   output logic       enviado,
   output logic [1:0] db_estado_tx
);

   logic [EV_W-1:0] ev_in, ev_cur, ev_prev, rise_c, pend, clr_c;
   logic            hb_pend, hb_sel_c, any_c, load_c;
   logic [7:0]      hb_byte_c, dados_c;

   assign ev_in  = {erro_timeout_ebulidor, erro_sem_xicara, fim};
   assign rise_c = ev_cur & ~ev_prev;
   assign any_c  = (|pend) | hb_pend;
   assign load_c = any_c & (~ocupado | enviado);

   // Input register and edge-detect history; preset high so levels present at reset are ignored
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ev_cur  <= '1;
         ev_prev <= '1;
      end else begin
         ev_cur  <= ev_in;
         ev_prev <= ev_cur;
      end
   end

   // Priority pick of the byte to send and the flag it retires
   always_comb begin
      dados_c  = hb_byte_c;
      clr_c    = '0;
      hb_sel_c = 1'b0;
      if (pend[EV_SEM]) begin
         dados_c        = COD_SEM_XICARA;
         clr_c[EV_SEM]  = 1'b1;
      end else if (pend[EV_TMO]) begin
         dados_c        = COD_TIMEOUT;
         clr_c[EV_TMO]  = 1'b1;
      end else if (pend[EV_FIM]) begin
         dados_c        = COD_FIM;
         clr_c[EV_FIM]  = 1'b1;
      end else begin
         hb_sel_c = 1'b1;
      end
   end

   // Pending flags: a new edge wins over the clear on the load edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend <= '0;
      end else begin
         pend <= rise_c | (pend & ~(clr_c & {EV_W{load_c}}));
      end
   end

`ifdef STATUS_HEARTBEAT_EN
   localparam int unsigned HW = $clog2(HEARTBEAT_DIV);

   logic [HW-1:0] hb_cnt;
   logic          hb_wrap_c;

   assign hb_wrap_c = (hb_cnt == HW'(HEARTBEAT_DIV - 1));
   assign hb_byte_c = {HB_PREFIX, db_estado};

   // Free-running heartbeat divider and its coalescing pending flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hb_cnt  <= '0;
         hb_pend <= 1'b0;
      end else begin
         hb_cnt  <= hb_wrap_c ? '0 : hb_cnt + HW'(1);
         hb_pend <= hb_wrap_c | (hb_pend & ~(load_c & hb_sel_c));
      end
   end
`else
   logic unused_cfg;

   assign hb_pend    = 1'b0;
   assign hb_byte_c  = 8'h00;
   assign unused_cfg = ^{db_estado, hb_sel_c, 32'(HEARTBEAT_DIV)};
`endif

   uart_tx_8n1 #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart (
      .clock   (clock),
      .reset   (reset),
      .partida (any_c),
      .dados   (dados_c),
      .saida   (tx_esp),
      .ocupado (ocupado),
      .pronto  (enviado),
      .estado  (db_estado_tx)
   );

endmodule
